fc_stream: RTL and testbench

FC_STREAM -- requirements
Module: fc_stream

---
 rtl/fc_stream.sv | 202 ++++++++++++++++++++
 tb/tb_fc_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_stream.sv
// fc_stream: streaming fully-connected layer; one activation per transfer, weights held in an external 1-cycle-latency RAM.
// Build option FC_STREAM_RELU_EN: when defined, negative neuron results are presented as zero on out_data.
module fc_stream #(
  parameter int NUM_IN  = 1024,
  parameter int NUM_OUT = 10,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int IN_AW   = 10,
  parameter int OUT_AW  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_weights,
  input  logic                    in_valid,
  output logic                    in_rdy,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [IN_AW-1:0]        in_idx,
  input  logic [OUT_AW-1:0]       in_idx2,
  output logic                    out_valid,
  input  logic                    out_rdy,
  output logic [DATA_W-1:0]       out_data,
  output logic [OUT_AW-1:0]       out_idx,
  output logic                    wt_we,
  output logic [IN_AW+OUT_AW-1:0] wt_addr,
  output logic [DATA_W-1:0]       wt_wdata,
  input  logic [DATA_W-1:0]       wt_rdata,
  output logic                    seq_err
);

  localparam int CW = OUT_AW + 2;
  localparam int PW = 2 * DATA_W;
  localparam logic [CW-1:0]     NOUT_C   = CW'(NUM_OUT);
  localparam logic [CW-1:0]     LAST_C   = CW'(NUM_OUT + 1);
  localparam logic [OUT_AW:0]   NOUT_J   = (OUT_AW + 1)'(NUM_OUT);
  localparam logic [IN_AW-1:0]  LAST_IN  = IN_AW'(NUM_IN - 1);
  localparam logic [OUT_AW-1:0] LAST_OUT = OUT_AW'(NUM_OUT - 1);

  typedef enum logic [1:0] {REC = 2'd0, MAC = 2'd1, SEND = 2'd2} state_t;

  state_t                    state_q;
  logic [IN_AW-1:0]          exp_q;
  logic [DATA_W-1:0]         x_q;
  logic [CW-1:0]             c_q;
  logic [DATA_W-1:0]         acc_q [NUM_OUT];
  logic                      out_valid_q;
  logic [DATA_W-1:0]         out_data_q;
  logic [OUT_AW-1:0]         out_idx_q;
  logic                      wt_we_q;
  logic [IN_AW+OUT_AW-1:0]   wt_addr_q;
  logic [DATA_W-1:0]         wt_wdata_q;
  logic                      seq_err_q;

  logic [OUT_AW-1:0]         mac_j_s;
  logic [DATA_W-1:0]         acc_cur_s;
  logic signed [PW-1:0]      prod_s;
  logic signed [PW-1:0]      shift_s;
  logic signed [PW:0]        sum_s;
  logic [DATA_W-1:0]         acc_d;
  logic [OUT_AW-1:0]         nxt_idx_s;
  logic [DATA_W-1:0]         nxt_data_s;

  function automatic logic [DATA_W-1:0] sat(input logic signed [PW:0] v);
    logic signed [PW:0] maxv;
    logic signed [PW:0] minv;
    maxv = {{(DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    minv = {{(DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};
    if (v > maxv) begin
      sat = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (v < minv) begin
      sat = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      sat = v[DATA_W-1:0];
    end
  endfunction

  function automatic logic [DATA_W-1:0] post(input logic [DATA_W-1:0] a);
`ifdef FC_STREAM_RELU_EN
    if (a[DATA_W-1]) begin
      post = {DATA_W{1'b0}};
    end else begin
      post = a;
    end
`else
    post = a;
`endif
  endfunction

  assign in_rdy    = (state_q == REC);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign wt_we     = wt_we_q;
  assign wt_addr   = wt_addr_q;
  assign wt_wdata  = wt_wdata_q;
  assign seq_err   = seq_err_q;

  // Multiply-accumulate datapath: the weight read back this cycle belongs to neuron c_q-2.
  always_comb begin
    mac_j_s   = OUT_AW'(c_q - CW'(2));
    acc_cur_s = {DATA_W{1'b0}};
    if ({1'b0, mac_j_s} < NOUT_J) begin
      acc_cur_s = acc_q[mac_j_s];
    end else begin
      acc_cur_s = {DATA_W{1'b0}};
    end
    prod_s  = $signed(wt_rdata) * $signed(x_q);
    shift_s = prod_s >>> FRAC_W;
    sum_s   = $signed({{(DATA_W + 1){acc_cur_s[DATA_W-1]}}, acc_cur_s})
            + $signed({shift_s[PW-1], shift_s});
    acc_d   = sat(sum_s);
  end

  // Next result to present in SEND.
  always_comb begin
    nxt_idx_s  = out_idx_q + OUT_AW'(1);
    nxt_data_s = {DATA_W{1'b0}};
    if ({1'b0, nxt_idx_s} < NOUT_J) begin
      nxt_data_s = post(acc_q[nxt_idx_s]);
    end else begin
      nxt_data_s = {DATA_W{1'b0}};
    end
  end

  // Control FSM plus all registered outputs and accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REC;
      exp_q       <= {IN_AW{1'b0}};
      x_q         <= {DATA_W{1'b0}};
      c_q         <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_idx_q   <= {OUT_AW{1'b0}};
      wt_we_q     <= 1'b0;
      wt_addr_q   <= {(IN_AW + OUT_AW){1'b0}};
      wt_wdata_q  <= {DATA_W{1'b0}};
      seq_err_q   <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
        acc_q[k] <= {DATA_W{1'b0}};
      end
    end else begin
      wt_we_q <= 1'b0;
      case (state_q)
        REC: begin
          if (in_valid) begin
            if (load_weights) begin
              wt_we_q    <= 1'b1;
              wt_addr_q  <= {in_idx, in_idx2};
              wt_wdata_q <= in_data;
            end else if (in_idx == exp_q) begin
              x_q     <= in_data;
              c_q     <= {CW{1'b0}};
              state_q <= MAC;
            end else begin
              seq_err_q <= 1'b1;
            end
          end
        end
        MAC: begin
          // Address issue leads accumulation by two cycles: one register, one RAM latency.
          c_q <= c_q + CW'(1);
          if (c_q < NOUT_C) begin
            wt_addr_q <= {exp_q, c_q[OUT_AW-1:0]};
          end
          if (c_q >= CW'(2)) begin
            acc_q[mac_j_s] <= acc_d;
          end
          if (c_q == LAST_C) begin
            if (exp_q == LAST_IN) begin
              exp_q       <= {IN_AW{1'b0}};
              state_q     <= SEND;
              out_valid_q <= 1'b1;
              out_idx_q   <= {OUT_AW{1'b0}};
              out_data_q  <= post(acc_q[0]);
            end else begin
              exp_q   <= exp_q + IN_AW'(1);
              state_q <= REC;
            end
          end
        end
        SEND: begin
          if (out_rdy) begin
            if (out_idx_q == LAST_OUT) begin
              out_valid_q <= 1'b0;
              state_q     <= REC;
              for (int k = 0; k < NUM_OUT; k++) begin
                acc_q[k] <= {DATA_W{1'b0}};
              end
            end else begin
              out_idx_q  <= nxt_idx_s;
              out_data_q <= nxt_data_s;
            end
          end
        end
        default: begin
          state_q <= REC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_stream.sv
// Self-checking bench for fc_stream: constant vector table, hand-written corner sequences, random frames vs. an arithmetic model.
`timescale 1ns/1ps
module tb_fc_stream;
  localparam int NI = 4, NO = 3, DW = 16, FW = 8, IAW = 2, OAW = 2;

  logic clk = 1'b0;
  logic rst, load_weights, in_valid, in_rdy, out_valid, out_rdy, wt_we, seq_err;
  logic [DW-1:0] in_data, out_data, wt_wdata, wt_rdata;
  logic [IAW-1:0] in_idx;
  logic [OAW-1:0] in_idx2, out_idx;
  logic [IAW+OAW-1:0] wt_addr;

  always #5 clk = ~clk;

  fc_stream #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .FRAC_W(FW), .IN_AW(IAW), .OUT_AW(OAW)) dut (
    .clk(clk), .rst(rst), .load_weights(load_weights), .in_valid(in_valid), .in_rdy(in_rdy),
    .in_data(in_data), .in_idx(in_idx), .in_idx2(in_idx2), .out_valid(out_valid), .out_rdy(out_rdy),
    .out_data(out_data), .out_idx(out_idx), .wt_we(wt_we), .wt_addr(wt_addr), .wt_wdata(wt_wdata),
    .wt_rdata(wt_rdata), .seq_err(seq_err));

  // External weight RAM, one-cycle read latency.
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (wt_we) ram[wt_addr] <= wt_wdata;
    wt_rdata <= ram[wt_addr];
  end

  int n_cmp = 0, n_bad = 0;
  logic [15:0] wm [NI][NO];
  logic [15:0] xv [NI];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: sum of (w*x)>>>FRAC over inputs, saturated after each addition.
  function automatic logic [15:0] ref_out(input int j);
    longint acc, p;
    acc = 0;
    for (int i = 0; i < NI; i++) begin
      p = longint'($signed(wm[i][j])) * longint'($signed(xv[i]));
      acc = acc + (p >>> FW);
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
    end
`ifdef FC_STREAM_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return 16'(acc);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_in_rdy"}, in_rdy, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_wt_we"}, wt_we, 0);
    chk({tag, "_wt_addr"}, wt_addr, 0);
    chk({tag, "_wt_wdata"}, wt_wdata, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
  endtask

  task automatic load_w(input int i, input int j, input logic [15:0] v);
    @(negedge clk);
    load_weights = 1'b1; in_valid = 1'b1; in_idx = IAW'(i); in_idx2 = OAW'(j); in_data = v;
    @(posedge clk); #1;
    in_valid = 1'b0; load_weights = 1'b0;
    chk("wt_we", wt_we, 1);
    chk("wt_addr", wt_addr, {IAW'(i), OAW'(j)});
    chk("wt_wdata", wt_wdata, v);
    wm[i][j] = v;
  endtask

  task automatic load_uniform(input logic [15:0] v);
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NO; j++) load_w(i, j, v);
    @(posedge clk); #1;
    chk("wt_we_drop", wt_we, 0);
  endtask

  task automatic send_in(input logic [IAW-1:0] idx, input logic [15:0] val);
    int n;
    n = 0;
    @(negedge clk);
    load_weights = 1'b0; in_valid = 1'b1; in_idx = idx; in_data = val;
    while (!in_rdy && n < 200) begin @(negedge clk); n++; end
    if (!in_rdy) chk("in_rdy_timeout", in_rdy, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic measure_rdy(output int lat);
    lat = 0;
    while (!in_rdy && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic collect(input logic [47:0] e, input bit stall);
    int k, n;
    k = 0; n = 0;
    while (k < NO && n < 400) begin
      @(negedge clk);
      out_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_rdy) begin
        chk("out_idx", out_idx, k);
        chk("out_data", out_data, e[16*k +: 16]);
        k++;
      end
      n++;
    end
    if (k != NO) chk("out_timeout", k, NO);
    @(negedge clk);
    out_rdy = 1'b0;
    chk("out_valid_drop", out_valid, 0);
  endtask

  task automatic run_frame(input logic [63:0] x, input logic [47:0] e, input bit stall);
    for (int i = 0; i < NI; i++) begin
      xv[i] = x[16*i +: 16];
      send_in(IAW'(i), xv[i]);
    end
    collect(e, stall);
  endtask

  typedef struct {
    logic [15:0] w;
    logic [63:0] x;
    logic [15:0] e_raw;
    logic [15:0] e_relu;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [15:0] e, r;
    logic [47:0] ev;
    logic [63:0] xr;

    tbl[0] = '{16'h0100, {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 16'h0A00, 16'h0A00};
    tbl[1] = '{16'h7FFF, {4{16'h7FFF}}, 16'h7FFF, 16'h7FFF};
    tbl[2] = '{16'h8000, {4{16'h7FFF}}, 16'h8000, 16'h0000};
    tbl[3] = '{16'h0080, {4{16'h0100}}, 16'h0200, 16'h0200};
    tbl[4] = '{16'hFF00, {4{16'h0100}}, 16'hFC00, 16'h0000};
    tbl[5] = '{16'hFFFF, {4{16'h0001}}, 16'hFFFC, 16'h0000};
    tbl[6] = '{16'h0200, {16'hFE00, 16'h0300, 16'hFF00, 16'h0100}, 16'h0200, 16'h0200};

    rst = 1'b0; load_weights = 1'b0; in_valid = 1'b0; in_data = '0;
    in_idx = '0; in_idx2 = '0; out_rdy = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset("reset");
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // Constant vectors with uniform weights.
    for (int t = 0; t < 7; t++) begin
`ifdef FC_STREAM_RELU_EN
      e = tbl[t].e_relu;
`else
      e = tbl[t].e_raw;
`endif
      load_uniform(tbl[t].w);
      run_frame(tbl[t].x, {e, e, e}, 1'b0);
    end

    // Neuron 1 weights -1.0, others +1.0.
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NO; j++) load_w(i, j, (j == 1) ? 16'hFF00 : 16'h0100);
`ifdef FC_STREAM_RELU_EN
    r = 16'h0000;
`else
    r = 16'hFC00;
`endif
    run_frame({4{16'h0100}}, {16'h0400, r, 16'h0400}, 1'b0);

    // Back-pressure: results held while out_rdy low.
    load_uniform(16'h0100);
    xr = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    for (int i = 0; i < NI; i++) send_in(IAW'(i), xr[16*i +: 16]);
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_idx", out_idx, 0);
      chk("hold_data", out_data, 16'h0A00);
    end
    collect({3{16'h0A00}}, 1'b0);

    // Out-of-order index is dropped and flagged; in_rdy latency is NUM_OUT+2.
    send_in(2'd0, 16'h0100);
    measure_rdy(lat);
    chk("rdy_latency", lat, NO + 2);
    chk("seq_err_before", seq_err, 0);
    send_in(2'd2, 16'h7000);
    chk("seq_err_set", seq_err, 1);
    chk("rdy_after_drop", in_rdy, 1);
    send_in(2'd1, 16'h0100);
    send_in(2'd2, 16'h0100);
    measure_rdy(lat);
    chk("no_early_frame", out_valid, 0);
    send_in(2'd3, 16'h0100);
    collect({3{16'h0400}}, 1'b0);
    chk("seq_err_sticky", seq_err, 1);

    // Load during MAC ignored, then reset mid-MAC discards partial frame.
    send_in(2'd0, 16'h0100);
    send_in(2'd1, 16'h0200);
    @(negedge clk);
    load_weights = 1'b1; in_valid = 1'b1; in_idx2 = 2'd1; in_data = 16'hDEAD;
    @(posedge clk); #1;
    chk("mac_load_ignored", wt_we, 0);
    load_weights = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_reset("midmac");
    @(negedge clk); rst = 1'b0;
    run_frame({16'h0400, 16'h0300, 16'h0200, 16'h0100}, {3{16'h0A00}}, 1'b0);

    // Random frames against the reference model.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NI; i++)
        for (int j = 0; j < NO; j++)
          load_w(i, j, (f % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024);
      for (int i = 0; i < NI; i++) begin
        xr[16*i +: 16] = (f % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
        xv[i] = xr[16*i +: 16];
      end
      for (int j = 0; j < NO; j++) ev[16*j +: 16] = ref_out(j);
      run_frame(xr, ev, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
